// File: rtl/smg_scan_decoder.sv
// -----------------------------------------------------------------------------
// smg_scan_decoder
// Receive-side monitor for a two-digit, multiplexed seven-segment display bus.
// Each column/row pair must stay unchanged for STABLE_CYCLES registered samples
// before it is captured. This rejects glitches while the scan is changing.
// A captured segment pattern is decoded back to a hex nibble. When both digits
// have been captured, the byte is presented with a one-cycle strobe. If no
// digit select is seen for TIMEOUT_CYCLES cycles, the display is reported
// blank.
//
// Ports
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   column_scan_signal  [1:0] active-low digit select: 2'b10 ones, 2'b01 tens
//   row_scan_signal     [7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   number_data         [7:0] {tens, ones} of the last complete frame
//   data_valid          one-cycle strobe; number_data updated this cycle
//   seg_error           valid with data_valid; a digit in the frame was undecodable
//   display_blank       level; no valid digit select for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module smg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] column_scan_signal,
  input  logic [7:0] row_scan_signal,
  output logic [7:0] number_data,
  output logic       data_valid,
  output logic       seg_error,
  output logic       display_blank
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      STABLE_N = 8'(STABLE_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  // Decode the active-low g..a pattern. The result is {error, nibble}.
  // Unknown patterns give nibble 0 and set the error bit.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40: decode_seg = 5'h00;  7'h79: decode_seg = 5'h01;
      7'h24: decode_seg = 5'h02;  7'h30: decode_seg = 5'h03;
      7'h19: decode_seg = 5'h04;  7'h12: decode_seg = 5'h05;
      7'h02: decode_seg = 5'h06;  7'h78: decode_seg = 5'h07;
      7'h00: decode_seg = 5'h08;  7'h10: decode_seg = 5'h09;
      7'h08: decode_seg = 5'h0A;  7'h03: decode_seg = 5'h0B;
      7'h46: decode_seg = 5'h0C;  7'h21: decode_seg = 5'h0D;
      7'h06: decode_seg = 5'h0E;  7'h0E: decode_seg = 5'h0F;
      default: decode_seg = 5'h10;
    endcase
  endfunction

  logic [9:0]      in_d, in_q;
  state_t          state_d, state_q;
  logic [7:0]      cnt_d, cnt_q;
  logic [3:0]      ones_d, ones_q, tens_d, tens_q;
  logic            ones_err_d, ones_err_q, tens_err_d, tens_err_q;
  logic [1:0]      seen_d, seen_q;
  logic [7:0]      number_d, number_q;
  logic            valid_d, valid_q, err_d, err_q, blank_d, blank_q;
  logic [TO_W-1:0] to_d, to_q;

  logic       col_ok, same, capture, sel_tens;
  logic [1:0] seen_new;
  logic [4:0] dec;

  // The sample arriving at the input register is compared against the sample
  // already held there. The count therefore equals the number of identical
  // registered samples, and the STABLE_CYCLES-th sample is captured on the
  // edge that registers it.
  assign in_d     = {column_scan_signal, row_scan_signal};
  assign col_ok   = (in_d[9:8] == 2'b10) || (in_d[9:8] == 2'b01);
  assign same     = (in_d == in_q);
  assign sel_tens = in_d[8];
  assign dec      = decode_seg(in_d[6:0]);  // dp is ignored

  // Stability FSM
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!col_ok) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
        S_SETTLE: begin
          if (same) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == STABLE_N) begin
              capture = 1'b1;
              state_d = S_HELD;
            end
          end else begin
            cnt_d = 8'd1;
          end
        end
        S_HELD: begin
          if (!same) begin
            state_d = S_SETTLE;
            cnt_d   = 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Capture, frame assembly and timeout
  always_comb begin
    ones_d     = ones_q;
    tens_d     = tens_q;
    ones_err_d = ones_err_q;
    tens_err_d = tens_err_q;
    seen_d     = seen_q;
    number_d   = number_q;
    err_d      = err_q;
    blank_d    = blank_q;
    valid_d    = 1'b0;
    seen_new   = seen_q;

    if (col_ok)              to_d = '0;
    else if (to_q != TO_MAX) to_d = to_q + 1'b1;
    else                     to_d = to_q;

    if (capture) begin
      if (sel_tens) begin
        tens_d     = dec[3:0];
        tens_err_d = dec[4];
        seen_new   = seen_q | 2'b10;
      end else begin
        ones_d     = dec[3:0];
        ones_err_d = dec[4];
        seen_new   = seen_q | 2'b01;
      end
      blank_d = 1'b0;
      if (seen_new == 2'b11) begin
        number_d = {tens_d, ones_d};
        err_d    = tens_err_d | ones_err_d;
        valid_d  = 1'b1;
        seen_d   = 2'b00;
      end else begin
        seen_d = seen_new;
      end
    end else if (to_d == TO_MAX) begin
      // Capture needs a valid column, so the timeout cannot fire on the same
      // edge. Any partial frame is discarded, and number_data keeps its value.
      blank_d = 1'b1;
      seen_d  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      in_q       <= {2'b11, 8'hFF};
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_err_q <= 1'b0;
      tens_err_q <= 1'b0;
      seen_q     <= 2'b00;
      number_q   <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      blank_q    <= 1'b0;
      to_q       <= '0;
    end else begin
      in_q       <= in_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      ones_err_q <= ones_err_d;
      tens_err_q <= tens_err_d;
      seen_q     <= seen_d;
      number_q   <= number_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      blank_q    <= blank_d;
      to_q       <= to_d;
    end
  end

  assign number_data   = number_q;
  assign data_valid    = valid_q;
  assign seg_error     = err_q;
  assign display_blank = blank_q;

endmodule

// File: tb/tb_smg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_smg_scan_decoder
// Directed bench for smg_scan_decoder with STABLE_CYCLES=4 and
// TIMEOUT_CYCLES=16. Every expected value is worked out by hand from the
// segment table.
// -----------------------------------------------------------------------------
module tb_smg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] column_scan_signal;
  logic [7:0] row_scan_signal;
  logic [7:0] number_data;
  logic       data_valid, seg_error, display_blank;

  int total = 0;
  int bad   = 0;

  // Results recorded by the most recent hold() call
  int         dv_n;
  int         dv_at;
  logic [7:0] dv_num;
  logic       dv_err;

  smg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .column_scan_signal (column_scan_signal),
    .row_scan_signal    (row_scan_signal),
    .number_data        (number_data),
    .data_valid         (data_valid),
    .seg_error          (seg_error),
    .display_blank      (display_blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one column/row pair for n clock cycles. Outputs are sampled 1 ns
  // after each rising edge, and any data_valid pulses are recorded.
  task automatic hold(input logic [1:0] col, input logic [7:0] row, input int n);
    dv_n   = 0;
    dv_at  = -1;
    column_scan_signal = col;
    row_scan_signal    = row;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (data_valid) begin
        if (dv_n == 0) dv_at = i;
        dv_n++;
        dv_num = number_data;
        dv_err = seg_error;
      end
    end
  endtask

  int dv_sum;

  initial begin
    dv_num = 8'h00;
    dv_err = 1'b0;

    // Reset with a valid ones digit '0' on the bus
    rst = 1'b1;
    column_scan_signal = 2'b10;
    row_scan_signal    = 8'hC0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_number", number_data, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_error", seg_error, 1'b0);
    check("rst_blank", display_blank, 1'b0);
    hold(2'b10, 8'hC0, 6);
    check("rst_no_frame", dv_n, 0);

    // Basic frame: ones 5 (0x92), tens 2 (0xA4)
    hold(2'b10, 8'h92, 6);
    check("f25_ones_no_dv", dv_n, 0);
    hold(2'b01, 8'hA4, 6);
    check("f25_dv_count", dv_n, 1);
    check("f25_dv_latency", dv_at, 3);
    check("f25_number", dv_num, 8'h25);
    check("f25_error", dv_err, 1'b0);
    check("f25_hold_number", number_data, 8'h25);

    // Glitch filter: 0xF9 ('1') is held only 3 cycles, then 0xB0 ('3')
    hold(2'b10, 8'hF9, 3);
    check("glitch_short_no_dv", dv_n, 0);
    hold(2'b10, 8'hB0, 6);
    check("glitch_ones_no_dv", dv_n, 0);
    hold(2'b01, 8'hC0, 6);
    check("glitch_dv_count", dv_n, 1);
    check("glitch_number", dv_num, 8'h03);

    // Invalid columns do not capture and keep the seen mask
    hold(2'b10, 8'h82, 6);                       // ones '6'
    hold(2'b00, 8'h80, 6);
    check("inv_both_no_dv", dv_n, 0);
    hold(2'b11, 8'hFF, 6);
    check("inv_none_no_dv", dv_n, 0);
    check("inv_number_held", number_data, 8'h03);
    hold(2'b01, 8'hC0, 6);                       // tens '0'
    check("inv_dv_count", dv_n, 1);
    check("inv_number", dv_num, 8'h06);

    // Undecodable pattern: segments all off
    hold(2'b10, 8'hFF, 6);
    hold(2'b01, 8'hC0, 6);
    check("err_dv_count", dv_n, 1);
    check("err_number", dv_num, 8'h00);
    check("err_flag", dv_err, 1'b1);

    // Duplicate ones capture overwrites: 8, then 9, then tens A
    hold(2'b10, 8'h80, 6);
    dv_sum = dv_n;
    hold(2'b10, 8'h90, 6);
    dv_sum += dv_n;
    check("dup_no_early_dv", dv_sum, 0);
    hold(2'b01, 8'h88, 6);
    check("dup_dv_count", dv_n, 1);
    check("dup_number", dv_num, 8'hA9);
    check("dup_error", dv_err, 1'b0);

    // dp cleared (0x10) decodes the same as dp set (0x90); tens 'C' (0xC6)
    hold(2'b10, 8'h10, 6);
    hold(2'b01, 8'hC6, 6);
    check("dp_dv_count", dv_n, 1);
    check("dp_number", dv_num, 8'hC9);

    // Timeout: capture ones '1', then the bus goes idle
    hold(2'b10, 8'hF9, 6);
    check("to_blank_before", display_blank, 1'b0);
    hold(2'b11, 8'hFF, 20);
    check("to_no_dv", dv_n, 0);
    check("to_blank_set", display_blank, 1'b1);
    check("to_number_held", number_data, 8'hC9);
    // Tens '4' alone must not complete a frame, because the partial frame
    // was discarded
    hold(2'b01, 8'h99, 6);
    check("to_tens_no_dv", dv_n, 0);
    check("to_blank_cleared", display_blank, 1'b0);
    hold(2'b10, 8'h82, 6);
    check("to_dv_count", dv_n, 1);
    check("to_number", dv_num, 8'h46);
    check("to_error", dv_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
